// File: rtl/ysyx_24070016_exu_seq.sv
// Execute-stage sequencer: accepts decoded ops, holds them for 1 or MC_LAT
// cycles while the ALU works, and hands results to writeback; owns ebreak halt.
module ysyx_24070016_exu_seq #(
  parameter int XLEN   = 32,
  parameter int MC_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_sel_rs2Isimm,
  input  logic            in_multicycle,
  input  logic            in_ebreak,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  input  logic [XLEN-1:0] alu_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            halt,
  output logic [31:0]     retire_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [7:0] MC_INIT = 8'(MC_LAT - 1);

  state_t            state_r;
  state_t            state_nx_s;
  logic [7:0]        cnt_r;
  logic [XLEN-1:0]   src1_r;
  logic [XLEN-1:0]   src2_r;
  logic [XLEN-1:0]   imm_r;
  logic              sel_r;
  logic [XLEN-1:0]   out_result_r;
  logic              out_valid_r;
  logic              halt_r;
  logic [31:0]       retire_cnt_r;
  logic              in_ready_s;
  logic              accept_s;
  logic              retire_s;

  // Handshake qualifiers; a retire and a new accept may share a DONE cycle.
  always_comb begin
    in_ready_s = (state_r == IDLE) | ((state_r == DONE) & out_ready);
    accept_s   = in_valid & in_ready_s;
    retire_s   = (state_r == DONE) & out_ready;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = in_ebreak ? HALT : EXEC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 8'd0) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = EXEC;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nx_s = in_ebreak ? HALT : EXEC;
        end else if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      HALT: begin
        state_nx_s = HALT;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, operand latches, cycle counter, result and retire bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      src1_r       <= '0;
      src2_r       <= '0;
      imm_r        <= '0;
      sel_r        <= 1'b0;
      out_result_r <= '0;
      out_valid_r  <= 1'b0;
      halt_r       <= 1'b0;
      retire_cnt_r <= 32'd0;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= (state_nx_s == DONE);
      halt_r      <= (state_nx_s == HALT);
      if (accept_s) begin
        src1_r <= in_src1;
        src2_r <= in_src2;
        imm_r  <= in_imm;
        sel_r  <= in_sel_rs2Isimm;
        cnt_r  <= in_multicycle ? MC_INIT : 8'd0;
      end else if ((state_r == EXEC) && (cnt_r != 8'd0)) begin
        cnt_r <= cnt_r - 8'd1;
      end
      if ((state_r == EXEC) && (cnt_r == 8'd0)) begin
        out_result_r <= alu_result;
      end
      if (retire_s) begin
        retire_cnt_r <= retire_cnt_r + 32'd1;
      end
    end
  end

  // Operand mux works off the latched select so it stays stable until the next accept.
  always_comb begin
    alu_src1 = src1_r;
    if (sel_r) begin
      alu_src2 = imm_r;
    end else begin
      alu_src2 = src2_r;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign halt       = halt_r;
  assign retire_cnt = retire_cnt_r;

endmodule
